// File: rtl/bin2bcd_serial_pkg.sv
// Shared definitions for the serial binary-to-BCD converter.
package bin2bcd_serial_pkg;

    // Default geometry: a 36-bit cycle count needs 11 decimal digits,
    // and a 6-bit counter is enough to count 36 iterations.
    localparam int DEF_BIN_W  = 36;
    localparam int DEF_DIGITS = 11;
    localparam int DEF_CNT_W  = 6;

    // Converter states; the done pulse is a register, not a state.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bin2bcd_serial_bcd_add3_digit.sv
// One-digit double-dabble correction: digits of 5 or more get 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3_digit (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    // The input is a valid BCD digit, so the sum never exceeds 12.
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble converter: one correct-and-shift iteration per clock,
// with a start/busy/done handshake and a result register that only changes
// when a conversion completes, so downstream display paging stays coherent.
module bin2bcd_serial
    import bin2bcd_serial_pkg::*;
#(
    parameter int BIN_W  = DEF_BIN_W,
    parameter int DIGITS = DEF_DIGITS,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                  Clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      data,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out
);

    state_t                r_state;
    logic [BIN_W-1:0]      r_binSr;
    logic [4*DIGITS-1:0]   r_scratch;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_busy;
    logic                  r_done;
    logic [4*DIGITS-1:0]   r_bcd;

    logic [4*DIGITS-1:0]   w_corrected;
    logic [4*DIGITS-1:0]   w_shifted;

    // Every scratch digit is corrected in parallel before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .i_digit (r_scratch[4*g +: 4]),
            .o_digit (w_corrected[4*g +: 4])
        );
    end

    // The corrected scratch shifts left, taking the binary MSB into bit 0.
    assign w_shifted = {w_corrected[4*DIGITS-2:0], r_binSr[BIN_W-1]};

    // Handshake FSM, iteration counter, shift registers and result register.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_binSr   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_binSr   <= data;
                        r_scratch <= '0;
                        r_cnt     <= CNT_W'(BIN_W);
                        r_busy    <= 1'b1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_scratch <= w_shifted;
                    r_binSr   <= {r_binSr[BIN_W-2:0], 1'b0};
                    r_cnt     <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_bcd   <= w_shifted;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign bcd_out = r_bcd;

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Directed bench for the serial binary-to-BCD converter. Inputs change and
// outputs are sampled on the falling clock edge, away from the active edge.
module tb_bin2bcd_serial;

    logic        Clk;
    logic        reset_n;
    logic        start;
    logic [35:0] data;
    logic        busy;
    logic        done;
    logic [43:0] bcd_out;

    int total;
    int bad;

    bin2bcd_serial dut (
        .Clk     (Clk),
        .reset_n (reset_n),
        .start   (start),
        .data    (data),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    // Free-running 10 ns clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Pulse start for one rising edge, then scramble data so a late recapture shows up.
    task automatic applyStimulus(input logic [35:0] value);
        start = 1'b1;
        data  = value;
        @(negedge Clk);
        start = 1'b0;
        data  = 36'hA_5A5A_5A5A;
    endtask

    // Count rising edges until done is seen, and how many samples had busy high.
    task automatic waitDone(output int cycles, output int busyCycles);
        cycles     = 0;
        busyCycles = 0;
        while (cycles < 100) begin
            if (busy === 1'b1) busyCycles++;
            if (done === 1'b1) break;
            @(negedge Clk);
            cycles++;
        end
        if (cycles >= 100) cycles = -1;
    endtask

    // Reset state with reset_n held low.
    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        data    = '0;
        #3;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        total++; if (bcd_out !== 44'h0) begin bad++; $display("[TB] FAIL reset_bcd got=%h want=0", bcd_out); end
        @(negedge Clk);
        @(negedge Clk);
        reset_n = 1'b1;
        @(negedge Clk);
    endtask

    // Zero input: exact latency and busy duration.
    task automatic test_zero();
        int n, b;
        applyStimulus(36'd0);
        waitDone(n, b);
        total++; if (n !== 36) begin bad++; $display("[TB] FAIL zero_latency got=%0d want=36", n); end
        total++; if (b !== 36) begin bad++; $display("[TB] FAIL zero_busy_cycles got=%0d want=36", b); end
        total++; if (bcd_out !== 44'h000_0000_0000) begin bad++; $display("[TB] FAIL zero_result got=%h want=0", bcd_out); end
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL zero_busy_at_done got=%b want=0", busy); end
        @(negedge Clk);
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL zero_done_pulse got=%b want=0", done); end
    endtask

    // Largest 36-bit value.
    task automatic test_max();
        int n, b;
        applyStimulus(36'hF_FFFF_FFFF);
        waitDone(n, b);
        total++; if (n !== 36) begin bad++; $display("[TB] FAIL max_latency got=%0d want=36", n); end
        total++; if (bcd_out !== 44'h687_1947_6735) begin bad++; $display("[TB] FAIL max_result got=%h want=68719476735", bcd_out); end
        @(negedge Clk);
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL max_done_pulse got=%b want=0", done); end
    endtask

    // Mid values, with the first result held throughout the second conversion.
    task automatic test_hold();
        int n, b;
        int held;
        applyStimulus(36'd12345);
        waitDone(n, b);
        total++; if (bcd_out !== 44'h000_0001_2345) begin bad++; $display("[TB] FAIL mid_12345 got=%h want=12345", bcd_out); end
        @(negedge Clk);
        applyStimulus(36'd999);
        held = 1;
        for (int i = 0; i < 100; i++) begin
            if (done === 1'b1) break;
            if (bcd_out !== 44'h000_0001_2345) held = 0;
            @(negedge Clk);
        end
        total++; if (held !== 1) begin bad++; $display("[TB] FAIL hold_result got=changed want=12345 held"); end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL mid_999_done got=%b want=1", done); end
        total++; if (bcd_out !== 44'h000_0000_0999) begin bad++; $display("[TB] FAIL mid_999 got=%h want=999", bcd_out); end
        @(negedge Clk);
    endtask

    // A start pulse while busy must be ignored entirely.
    task automatic test_busy_start();
        int n, b;
        int extraDone;
        applyStimulus(36'd12345);
        for (int i = 0; i < 9; i++) @(negedge Clk);
        applyStimulus(36'd777);
        waitDone(n, b);
        total++; if (n !== 26) begin bad++; $display("[TB] FAIL busy_start_latency got=%0d want=26", n); end
        total++; if (bcd_out !== 44'h000_0001_2345) begin bad++; $display("[TB] FAIL busy_start_result got=%h want=12345", bcd_out); end
        extraDone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (done === 1'b1 || busy === 1'b1) extraDone++;
        end
        total++; if (extraDone !== 0) begin bad++; $display("[TB] FAIL busy_start_second_conv got=%0d want=0", extraDone); end
    endtask

    // Start asserted in the done cycle begins a new conversion immediately.
    task automatic test_back_to_back();
        int n, b;
        applyStimulus(36'd5);
        waitDone(n, b);
        total++; if (bcd_out !== 44'h000_0000_0005) begin bad++; $display("[TB] FAIL b2b_first got=%h want=5", bcd_out); end
        applyStimulus(36'd1000000000);
        total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_busy got=%b want=1", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL b2b_done_clear got=%b want=0", done); end
        waitDone(n, b);
        total++; if (n !== 36) begin bad++; $display("[TB] FAIL b2b_latency got=%0d want=36", n); end
        total++; if (bcd_out !== 44'h010_0000_0000) begin bad++; $display("[TB] FAIL b2b_result got=%h want=1000000000", bcd_out); end
        @(negedge Clk);
    endtask

    // Asynchronous reset mid-conversion, then a clean conversion afterwards.
    task automatic test_reset_mid();
        int n, b;
        int spurious;
        applyStimulus(36'd12345);
        for (int i = 0; i < 19; i++) @(negedge Clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_done got=%b want=0", done); end
        total++; if (bcd_out !== 44'h0) begin bad++; $display("[TB] FAIL rst_mid_bcd got=%h want=0", bcd_out); end
        @(negedge Clk);
        @(negedge Clk);
        reset_n = 1'b1;
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (done === 1'b1 || busy === 1'b1) spurious++;
        end
        total++; if (spurious !== 0) begin bad++; $display("[TB] FAIL rst_mid_no_done got=%0d want=0", spurious); end
        applyStimulus(36'd42);
        waitDone(n, b);
        total++; if (n !== 36) begin bad++; $display("[TB] FAIL rst_after_latency got=%0d want=36", n); end
        total++; if (bcd_out !== 44'h000_0000_0042) begin bad++; $display("[TB] FAIL rst_after_result got=%h want=42", bcd_out); end
    endtask

    // Scenario sequence.
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_zero();
        test_max();
        test_hold();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
